// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the instruction fetch stage.
package fetch_pkg;
    localparam int PC_STEP    = 4;
    localparam int ALIGN_BITS = 2;
    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding {pc, instr} fetch entries.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign dout  = mem_q[rd_q];
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        // flush wins over any push or pop in the same cycle
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = din;
                wr_d        = nxt(wr_q);
            end
            if (do_pop) rd_d = nxt(rd_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, imem request issue, prefetch buffering and redirect squash.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  FIFO_DEPTH  = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    instr_pc,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = PC_WIDTH + INSTR_WIDTH;

    logic [PC_WIDTH-1:0] fpc_q, fpc_d, infl_pc_q, infl_pc_d;
    logic                infl_q, infl_d;
    logic                push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]       count;
    logic [EW-1:0]       head;

    assign instr_valid       = !fifo_empty;
    assign pop               = instr_valid && instr_ready;
    assign push              = infl_q && !redirect_valid;
    assign {instr_pc, instr} = head;
    assign imem_addr         = fpc_q;
    assign pc                = fpc_q;

    always_comb begin
        // buffered plus in-flight words never exceed the FIFO, so a push always has room
        imem_req  = rst && !redirect_valid &&
                    ((!fifo_full && (int'(count) + int'(infl_q) < FIFO_DEPTH)) || pop);
        infl_d    = imem_req;
        infl_pc_d = infl_pc_q;
        fpc_d     = fpc_q;
        if (redirect_valid) begin
            fpc_d = {redirect_pc[PC_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        end else if (imem_req) begin
            fpc_d     = fpc_q + PC_WIDTH'(PC_STEP);
            infl_pc_d = fpc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            fpc_q     <= fpc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({infl_pc_q, imem_rdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed fetch-stage checks with a delivery scoreboard.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, redirect_valid = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [7:0]  imem_addr, redirect_pc = '0, instr_pc, pc;
    logic [31:0] imem_rdata, instr;
    int          total = 0;
    int          bad = 0;
    fetch_entry_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return {26'b0, a[7:2]};
    endfunction

    always @(posedge clk) if (imem_req) imem_rdata <= rom(imem_addr);

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .pc             (pc)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input logic [7:0] p);
        sb.push_back('{pc: p, instr: rom(p)});
    endtask

    // mid-cycle scoreboard pop on handshake, then advance to just after the next edge
    task automatic step();
        fetch_entry_t e;
        @(negedge clk);
        check("no_overflow", dut.push && dut.fifo_full && !dut.pop, 0);
        if (rst && instr_valid && instr_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%h expected=none", {instr_pc, instr});
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_head", {instr_pc, instr}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_pc(8'(4 * i));
        #2;
        check("c0_req", imem_req, 1);
        check("c0_addr", imem_addr, 8'h00);
        step();
        #2;
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 8'h04);
        check("c1_valid", instr_valid, 0);
        step();
        #2;
        check("c2_valid", instr_valid, 1);
        check("c2_pc", instr_pc, 8'h00);
        check("c2_instr", instr, 0);
        for (int i = 3; i < 10; i++) begin
            step();
            #2;
            check("stream_valid", instr_valid, 1);
        end
        step();
        instr_ready = 1'b0;
        expect_pc(8'h20);
        expect_pc(8'h24);
        expect_pc(8'h28);
        for (int i = 0; i < 6; i++) begin
            #2;
            check("bp_req", imem_req, 0);
            check("bp_valid", instr_valid, 1);
            check("bp_pc", instr_pc, 8'h20);
            step();
        end
        instr_ready = 1'b1;
        #2;
        check("bp_resume_req", imem_req, 1);
        check("bp_resume_addr", imem_addr, 8'h28);
        step();
        step();
        step();
        instr_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        expect_pc(8'h40);
        expect_pc(8'h44);
        #2;
        check("rd_fpc_before", pc, 8'h34);
        check("rd_req", imem_req, 0);
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        #2;
        check("rd_t1_req", imem_req, 1);
        check("rd_t1_addr", imem_addr, 8'h40);
        check("rd_t1_valid", instr_valid, 0);
        step();
        step();
        #2;
        check("rd_valid", instr_valid, 1);
        check("rd_pc", instr_pc, 8'h40);
        check("rd_instr", instr, 32'h10);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 8'h43;
        expect_pc(8'h40);
        expect_pc(8'h44);
        #2;
        check("rd2_req", imem_req, 0);
        step();
        redirect_valid = 1'b0;
        #2;
        check("rd2_addr_aligned", imem_addr, 8'h40);
        step();
        step();
        #2;
        check("rd2_pc", instr_pc, 8'h40);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 8'hF8;
        expect_pc(8'hF8);
        expect_pc(8'hFC);
        expect_pc(8'h00);
        expect_pc(8'h04);
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        #2;
        check("wrap_pc", instr_pc, 8'h00);
        check("wrap_instr", instr, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("ar_req", imem_req, 0);
        check("ar_valid", instr_valid, 0);
        check("ar_pc", pc, 8'h00);
        check("ar_instr_pc", instr_pc, 0);
        check("ar_instr", instr, 0);
        check("sb_drained_pre_reset", sb.size(), 0);
        step();
        step();
        rst = 1'b1;
        expect_pc(8'h00);
        expect_pc(8'h04);
        expect_pc(8'h08);
        #2;
        check("ar_c0_req", imem_req, 1);
        check("ar_c0_addr", imem_addr, 8'h00);
        step();
        step();
        #2;
        check("ar_c2_valid", instr_valid, 1);
        check("ar_c2_pc", instr_pc, 8'h00);
        step();
        step();
        step();
        instr_ready = 1'b0;
        check("sb_drained_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
